// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//   Loads an instruction memory from a byte stream. The stream begins with a
//   16-bit big-endian word count, followed by that many 32-bit words sent
//   MSB-first. Each complete word is written to instruction memory with a
//   one-cycle WE pulse. The CPU is held in reset (cpu_hold) for the whole load.
//
// Parameters
//   MAX_WORDS  largest word count accepted; a larger count ends the load in ERR
//   ADDR_BASE  byte address of the first word written
//
// Ports
//   CLK        system clock; all state changes on its rising edge
//   RST        asynchronous reset, active low
//   start      one-cycle pulse that begins a load (ignored while busy)
//   in_valid   byte-stream data valid
//   in_data    byte-stream data
//   in_ready   loader accepts a byte this cycle
//   WE         instruction-memory write enable (one cycle per word)
//   W_Addr     instruction-memory byte address (held between writes)
//   W_Ins      instruction word to write (held between writes)
//   cpu_hold   holds the fetch stage/CPU in reset while loading
//   busy       loader is not idle
//   done       last load completed; sticky until the next start
//   err        last load had an oversize count; sticky until the next start
//   count      words written in the current or last load
// -----------------------------------------------------------------------------
module im_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] ADDR_BASE = 32'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        WE,
  output logic [31:0] W_Addr,
  output logic [31:0] W_Ins,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_BYTE   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  // Only the first three bytes of a word need storage; the fourth byte is
  // merged straight into W_Ins on the cycle it arrives.
  logic [23:0] acc_q, acc_d;
  logic [15:0] count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ins_q, ins_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] count_inc;

  assign in_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_BYTE);
  assign xfer      = in_valid && in_ready;
  assign len_full  = {len_hi_q, in_data};
  assign count_inc = count_q + 16'd1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      ins_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      ins_q    <= ins_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    count_d  = count_q;
    addr_d   = addr_q;
    ins_d    = ins_q;
    done_d   = done_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          idx_d = '0;
          if (len_full == 16'd0) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if ({16'd0, len_full} > 32'(MAX_WORDS)) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            state_d = S_BYTE;
          end
        end
      end

      S_BYTE: begin
        if (xfer) begin
          idx_d = idx_q + 2'd1;
          acc_d = {acc_q[15:0], in_data};
          if (idx_q == 2'd3) begin
            // Address and word are latched here so they are stable for the
            // whole WRITE cycle and hold afterwards.
            addr_d  = ADDR_BASE + {14'd0, count_q, 2'b00};
            ins_d   = {acc_q, in_data};
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        count_d = count_inc;
        if (count_inc == len_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_BYTE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign WE       = (state_q == S_WRITE);
  assign W_Addr   = addr_q;
  assign W_Ins    = ins_q;
  assign busy     = (state_q != S_IDLE);
  assign cpu_hold = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign count    = count_q;

endmodule
